// File: rtl/iq_demod_pkg.sv
// Shared constants and carrier tables for the IQ transmitter/demodulator pair.
// Tables hold round(127*cos/sin(2*pi*p/32)) as signed 8-bit values.
package iq_demod_pkg;

  localparam int ADC_W      = 10;
  localparam int ADC_MID    = 512;
  localparam int TBL_LEN    = 32;
  localparam int TBL_AW     = $clog2(TBL_LEN);
  localparam int DEF_PHSTEP = 2;
  localparam int X_W        = 11;
  localparam int PROD_W     = 19;

  function automatic logic signed [7:0] quarter_lut(input logic [3:0] k);
    case (k)
      4'd0:    quarter_lut = 8'sd127;
      4'd1:    quarter_lut = 8'sd125;
      4'd2:    quarter_lut = 8'sd117;
      4'd3:    quarter_lut = 8'sd106;
      4'd4:    quarter_lut = 8'sd90;
      4'd5:    quarter_lut = 8'sd71;
      4'd6:    quarter_lut = 8'sd49;
      4'd7:    quarter_lut = 8'sd25;
      4'd8:    quarter_lut = 8'sd0;
      default: quarter_lut = 8'sd0;
    endcase
  endfunction

  // Full cosine period folded onto the first quadrant.
  function automatic logic signed [7:0] cos_lut(input logic [TBL_AW-1:0] p);
    logic [TBL_AW-1:0] m;
    m = 5'd0;
    if (p <= 5'd8) begin
      cos_lut = quarter_lut(p[3:0]);
    end else if (p <= 5'd16) begin
      m       = 5'd16 - p;
      cos_lut = -quarter_lut(m[3:0]);
    end else if (p <= 5'd24) begin
      m       = p - 5'd16;
      cos_lut = -quarter_lut(m[3:0]);
    end else begin
      m       = 5'd0 - p;
      cos_lut = quarter_lut(m[3:0]);
    end
  endfunction

  function automatic logic signed [7:0] sin_lut(input logic [TBL_AW-1:0] p);
    sin_lut = cos_lut(p - 5'd8);
  endfunction

endpackage

// File: rtl/iq_demod_if.sv
// Result channel of the demodulator: I/Q pair with valid/ready and sticky overrun.
interface iq_demod_if #(
  parameter int IQW = 12
);
  logic signed [IQW-1:0] i_out;
  logic signed [IQW-1:0] q_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overrun;

  modport master (output i_out, q_out, out_valid, overrun, input out_ready);
  modport slave  (input i_out, q_out, out_valid, overrun, output out_ready);
endinterface

// File: rtl/iq_demod_mixer.sv
// Carrier table lookup and I/Q multiplies, registered as the second pipeline stage.
module iq_mixer
  import iq_demod_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [X_W-1:0]    x,
  input  logic [TBL_AW-1:0]        idx,
  output logic signed [PROD_W-1:0] prod_i,
  output logic signed [PROD_W-1:0] prod_q
);

  logic signed [PROD_W-1:0] prod_i_s;
  logic signed [PROD_W-1:0] prod_q_s;

  // Q is negated so its sign matches the transmitter's dac = 512 + I*cos - Q*sin
  always_comb begin
    prod_i_s = PROD_W'(x) * PROD_W'(cos_lut(idx));
    prod_q_s = -(PROD_W'(x) * PROD_W'(sin_lut(idx)));
  end

  // Product register
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_i <= '0;
      prod_q <= '0;
    end else begin
      prod_i <= prod_i_s;
      prod_q <= prod_q_s;
    end
  end

endmodule

// File: rtl/iq_demod.sv
// Coherent I/Q demodulator: mix ADC samples with a local carrier, integrate
// 2^NLOG2 products per result and hand results out over a valid/ready channel.
module iq_demod
  import iq_demod_pkg::*;
#(
  parameter int IQW    = 12,
  parameter int NLOG2  = 4,
  parameter int PHSTEP = DEF_PHSTEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  adcval,
  input  logic [TBL_AW-1:0] phase_ofs,
  iq_demod_if.master        res
);

  localparam int ACC_W = PROD_W + NLOG2;

  logic [TBL_AW-1:0]        tphase_r;
  logic [TBL_AW-1:0]        idx_r;
  logic [NLOG2-1:0]         cnt_r;
  logic signed [X_W-1:0]    x_s;
  logic signed [X_W-1:0]    x_r;
  logic                     last1_r;
  logic                     last2_r;
  logic                     dump_r;
  logic signed [PROD_W-1:0] prod_i;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_i_r;
  logic signed [ACC_W-1:0]  acc_q_r;
  logic signed [IQW-1:0]    i_r;
  logic signed [IQW-1:0]    q_r;
  logic                     valid_r;
  logic                     overrun_r;

  assign x_s = $signed({1'b0, adcval}) - $signed(X_W'(ADC_MID));

  // Stage 1: centre the sample and tag it with its carrier index and block-end flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tphase_r <= '0;
      cnt_r    <= '0;
      x_r      <= '0;
      idx_r    <= '0;
      last1_r  <= 1'b0;
    end else begin
      tphase_r <= tphase_r + TBL_AW'(PHSTEP);
      cnt_r    <= cnt_r + NLOG2'(1);
      x_r      <= x_s;
      idx_r    <= tphase_r + phase_ofs;
      last1_r  <= (cnt_r == {NLOG2{1'b1}});
    end
  end

  iq_mixer u_mixer (
    .clk    (clk),
    .rst    (rst),
    .x      (x_r),
    .idx    (idx_r),
    .prod_i (prod_i),
    .prod_q (prod_q)
  );

  // Stage 3: integrate; the cycle after a block's last product, restart from the new product
  always_ff @(posedge clk) begin
    if (rst) begin
      last2_r <= 1'b0;
      dump_r  <= 1'b0;
      acc_i_r <= '0;
      acc_q_r <= '0;
    end else begin
      last2_r <= last1_r;
      dump_r  <= last2_r;
      if (dump_r) begin
        acc_i_r <= ACC_W'(prod_i);
        acc_q_r <= ACC_W'(prod_q);
      end else begin
        acc_i_r <= acc_i_r + ACC_W'(prod_i);
        acc_q_r <= acc_q_r + ACC_W'(prod_q);
      end
    end
  end

  // Result register: a dump always loads, an unconsumed result being replaced is an overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r       <= '0;
      q_r       <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (dump_r) begin
      i_r       <= acc_i_r[ACC_W-1 -: IQW];
      q_r       <= acc_q_r[ACC_W-1 -: IQW];
      valid_r   <= 1'b1;
      overrun_r <= overrun_r | (valid_r & ~res.out_ready);
    end else begin
      valid_r   <= valid_r & ~res.out_ready;
    end
  end

  assign res.i_out     = i_r;
  assign res.q_out     = q_r;
  assign res.out_valid = valid_r;
  assign res.overrun   = overrun_r;

endmodule
